clutter_map_upd_engine: RTL

// - Parametrised clutter-map update engine: streams one CPI of amplitude samples (range-major, NDOP Doppler per range),

---
 rtl/clutter_map_upd_engine.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/clutter_map_upd_engine.sv
// Clutter-map update engine.
// Streams one CPI of amplitude samples, fetches the stored map beat for the
// beam from DDR, applies the first-order recursion lane by lane, writes the
// beat back and emits a scaled CFAR threshold per cell.
// Optional build macro: CLUT_INIT_FRAME_EN. When it is defined, a frame started
// with init_req high seeds the map from the input and issues no reads.
module clutter_map_upd_engine #(
  parameter int          DW        = 16,
  parameter int          LANES     = 8,
  parameter int          NRANGE    = 2048,
  parameter int          NDOP      = 32,
  parameter int          NBEAM     = 120,
  parameter logic [48:0] BASE_ADDR = 49'd0
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic          frm_start,
  input  logic [15:0]   beam_id,
  input  logic [15:0]   recur_coeff,
  input  logic [15:0]   thr_scale,
  input  logic          init_req,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          fifo_wr_en_cmd,
  input  logic          fifo_full_cmd,
  output logic [63:0]   fifo_din_cmd,
  output logic          fifo_wr_en_wr,
  input  logic          fifo_wr_full,
  output logic [127:0]  fifo_din_wr,
  output logic          fifo_read_en,
  input  logic          fifo_read_empty,
  input  logic [127:0]  fifo_read_data,
  output logic          thresh_valid,
  output logic [15:0]   thresh_dat,
  output logic          busy,
  output logic          err_ovf,
  output logic          err_cfg
);

  localparam int NBEATS = (NRANGE * NDOP) / LANES;
  localparam int BW     = $clog2(NBEATS + 1);
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW     = DW + 18;
  localparam logic signed [PW-1:0] HALF_LSB   = PW'(32768);
  localparam logic [11:0]          BEAT_BYTES = 12'(LANES * DW / 8);

  typedef enum logic [2:0] {
    S_IDLE, S_RDCMD, S_COLLECT, S_RDDAT, S_CALC, S_WRITE
  } state_t;

  state_t                    state;
  logic [BW-1:0]             beat;
  logic [LW-1:0]             lane;
  logic [15:0]               beam_reg;
  logic [15:0]               alpha_reg;
  logic [15:0]               scale_reg;
  logic                      init_mode;
  logic [LANES-1:0][DW-1:0]  in_buf;
  logic [LANES-1:0][DW-1:0]  old_buf;
  logic [LANES-1:0][DW-1:0]  wr_beat;
  logic                      p1_valid;
  logic [DW-1:0]             p1_new;

`ifndef CLUT_INIT_FRAME_EN
  logic unused_init;
  assign init_mode   = 1'b0;
  assign unused_init = init_req;
`endif

  // Recursion for the selected lane: old + round(alpha * (in - old)), clipped
  logic [DW-1:0]        sel_in, sel_old, new_val;
  logic signed [DW:0]   diff;
  logic signed [PW-1:0] diff_x, alpha_x, prod, delta, sum;
  always_comb begin
    sel_in  = in_buf[lane];
    sel_old = old_buf[lane];
    diff    = $signed({1'b0, sel_in}) - $signed({1'b0, sel_old});
    diff_x  = {{(PW-DW-1){diff[DW]}}, diff};
    alpha_x = $signed({{(PW-16){1'b0}}, alpha_reg});
    prod    = diff_x * alpha_x;
    delta   = (prod + HALF_LSB) >>> 16;
    sum     = $signed({{(PW-DW){1'b0}}, sel_old}) + delta;
    if (init_mode)
      new_val = sel_in;
    else if (sum[PW-1])
      new_val = '0;
    else if (|sum[PW-2:DW])
      new_val = '1;
    else
      new_val = sum[DW-1:0];
  end

  // Threshold from the pipelined new value: round(new * scale / 256), saturated
  logic [DW+15:0] tprod;
  logic [DW+16:0] tsum;
  logic [15:0]    thr_val;
  always_comb begin
    tprod = {16'b0, p1_new} * {{DW{1'b0}}, scale_reg};
    tsum  = {1'b0, tprod} + (DW+17)'(128);
    if (|tsum[DW+16:24])
      thr_val = 16'hFFFF;
    else
      thr_val = tsum[23:8];
  end

  // Byte address of the current beat; reads and writes share it
  logic [48:0] cell_idx, byte_addr;
  always_comb begin
    cell_idx  = 49'(beam_reg) * 49'(NRANGE * NDOP) + 49'(beat) * 49'(LANES);
    byte_addr = BASE_ADDR + cell_idx * 49'(DW / 8);
  end

  // FIFO strobes are qualified by the live FIFO status so a push never lands on
  // a full FIFO and a pop never hits an empty one
  logic wr_go;
  assign wr_go          = (state == S_WRITE) && !fifo_full_cmd && !fifo_wr_full;
  assign fifo_wr_en_cmd = ((state == S_RDCMD) && !fifo_full_cmd) || wr_go;
  assign fifo_wr_en_wr  = wr_go;
  assign fifo_read_en   = (state == S_RDDAT) && !fifo_read_empty;
  assign fifo_din_cmd   = fifo_wr_en_cmd ?
                          {(state == S_RDCMD), 2'b00, byte_addr, BEAT_BYTES} : '0;
  assign fifo_din_wr    = fifo_wr_en_wr ? wr_beat : '0;

  // Frame sequencer, sample capture, update pipeline and sticky error flags
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      beat         <= '0;
      lane         <= '0;
      beam_reg     <= '0;
      alpha_reg    <= '0;
      scale_reg    <= '0;
      in_buf       <= '0;
      old_buf      <= '0;
      wr_beat      <= '0;
      p1_valid     <= 1'b0;
      p1_new       <= '0;
      in_ready     <= 1'b0;
      thresh_valid <= 1'b0;
      thresh_dat   <= '0;
      busy         <= 1'b0;
      err_ovf      <= 1'b0;
      err_cfg      <= 1'b0;
`ifdef CLUT_INIT_FRAME_EN
      init_mode    <= 1'b0;
`endif
    end else begin
      thresh_valid <= p1_valid;
      if (p1_valid)
        thresh_dat <= thr_val;
      p1_valid <= 1'b0;
      if ((in_valid && !in_ready) || (frm_start && busy))
        err_ovf <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frm_start) begin
            if (beam_id < 16'(NBEAM)) begin
              beam_reg  <= beam_id;
              alpha_reg <= recur_coeff;
              scale_reg <= thr_scale;
              beat      <= '0;
              lane      <= '0;
              busy      <= 1'b1;
`ifdef CLUT_INIT_FRAME_EN
              init_mode <= init_req;
              if (init_req) begin
                state    <= S_COLLECT;
                in_ready <= 1'b1;
              end else begin
                state <= S_RDCMD;
              end
`else
              state <= S_RDCMD;
`endif
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        S_RDCMD: begin
          if (!fifo_full_cmd) begin
            state    <= S_COLLECT;
            in_ready <= 1'b1;
            lane     <= '0;
          end
        end
        S_COLLECT: begin
          if (in_valid && in_ready) begin
            in_buf[lane] <= in_data;
            if (lane == LW'(LANES - 1)) begin
              in_ready <= 1'b0;
              lane     <= '0;
              state    <= init_mode ? S_CALC : S_RDDAT;
            end else begin
              lane <= lane + LW'(1);
            end
          end
        end
        S_RDDAT: begin
          if (!fifo_read_empty) begin
            old_buf <= fifo_read_data;
            lane    <= '0;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          p1_valid      <= 1'b1;
          p1_new        <= new_val;
          wr_beat[lane] <= new_val;
          if (lane == LW'(LANES - 1)) begin
            lane  <= '0;
            state <= S_WRITE;
          end else begin
            lane <= lane + LW'(1);
          end
        end
        S_WRITE: begin
          if (wr_go) begin
            beat <= beat + BW'(1);
            if (beat == BW'(NBEATS - 1)) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else if (init_mode) begin
              state    <= S_COLLECT;
              in_ready <= 1'b1;
            end else begin
              state <= S_RDCMD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
